// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a show-ahead FIFO one word per frame:
// start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frames_sent
);

  localparam int BIT_CNT_W = $clog2(DATA_W) + 1;
  localparam logic [15:0]          BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    shreg;
  logic [DATA_W-1:0]    shreg_next;
  logic                 par_bit;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [15:0]          baud_cnt;
  logic                 bit_end;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ (PARITY_ODD != 0);
  endfunction

  assign busy       = (state != IDLE);
  assign shreg_next = shreg >> 1;

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    bit_end   = (baud_cnt == BAUD_LAST);
    case (state)
      IDLE: begin
        // Gated by rst_n so the FIFO never sees a pop while we are held in reset.
        if (rst_n && enable && !fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = START;
        end
      end
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_cnt == DATA_LAST) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && bit_cnt == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      par_bit     <= 1'b0;
      bit_cnt     <= '0;
      baud_cnt    <= '0;
      tx          <= 1'b1;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (fifo_pop) begin
          shreg   <= fifo_data;
          par_bit <= parity_of(fifo_data);
          tx      <= 1'b0;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 16'd1;
      end else begin
        // Bit boundary: load tx with the value of the bit that starts next.
        baud_cnt <= '0;
        case (state)
          START: begin
            tx      <= shreg[0];
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              tx      <= (PARITY_EN != 0) ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
            end
          end
          PARITY: tx <= 1'b1;
          STOP: begin
            if (bit_cnt == STOP_LAST) begin
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two configurations (8N1 and 8O2) share one emulated FIFO;
// a queue-of-line-levels model predicts tx/busy/pop/frame_done/frames_sent every cycle.
module tb_fifo_uart_tx;

  localparam int DW   = 8;
  localparam int BAUD = 4;
  localparam int HIST = 16384;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          enable     = 1'b0;
  logic          sel        = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          en_a, en_b;
  logic          pop_a, tx_a, busy_a, done_a;
  logic          pop_b, tx_b, busy_b, done_b;
  logic [15:0]   cnt_a, cnt_b;

  assign en_a = enable & ~sel;
  assign en_b = enable & sel;

  fifo_uart_tx #(.DATA_W(DW), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(pop_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a), .frames_sent(cnt_a));

  fifo_uart_tx #(.DATA_W(DW), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(pop_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b), .frames_sent(cnt_b));

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  bit            exp_q[$];
  bit            done_pend = 1'b0;
  logic [15:0]   exp_cnt[2];
  bit            pop_seen = 1'b0;
  int            pop_log[$];
  int            done_log[$];
  bit            tx_hist[HIST];
  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Expected line levels for one frame, one entry per clk.
  task automatic add_frame(input logic [DW-1:0] w);
    bit bits[$];
    bit par_en;
    int stops;
    par_en = sel;
    stops  = sel ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (par_en) bits.push_back(~(^w));
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < BAUD; k++) exp_q.push_back(bits[i]);
  endtask

  always @(negedge clk) begin
    logic s_pop, s_tx, s_busy, s_done, e_pop, e_tx;
    logic [15:0] s_cnt;
    cyc++;
    s_pop  = sel ? pop_b  : pop_a;
    s_tx   = sel ? tx_b   : tx_a;
    s_busy = sel ? busy_b : busy_a;
    s_done = sel ? done_b : done_a;
    s_cnt  = sel ? cnt_b  : cnt_a;
    if (cyc < HIST) tx_hist[cyc] = s_tx;
    if (s_pop)  pop_log.push_back(cyc);
    if (s_done) done_log.push_back(cyc);
    if (!rst_n) begin
      exp_q.delete();
      done_pend  = 1'b0;
      exp_cnt[0] = '0;
      exp_cnt[1] = '0;
      pop_seen   = 1'b0;
    end else begin
      e_pop = (exp_q.size() == 0) && enable && !fifo_empty;
      e_tx  = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
      check("tx", s_tx, e_tx);
      check("busy", s_busy, exp_q.size() != 0);
      check("frame_done", s_done, done_pend);
      check("fifo_pop", s_pop, e_pop);
      check("frames_sent", s_cnt, exp_cnt[sel]);
      check("unselected_busy", sel ? busy_a : busy_b, 1'b0);
      pop_seen  = s_pop;
      done_pend = 1'b0;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          done_pend    = 1'b1;
          exp_cnt[sel] = exp_cnt[sel] + 16'd1;
        end
      end
      if (e_pop) add_frame(fifo_data);
    end
  end

  function automatic void refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_seen = 1'b0;
    refresh();
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic wait_pops(input int target, input int limit);
    for (int i = 0; i < limit && pop_log.size() < target; i++) tick();
    if (pop_log.size() < target) check("wait_pop_timeout", pop_log.size(), target);
  endtask

  task automatic wait_dones(input int target, input int limit);
    for (int i = 0; i < limit && done_log.size() < target; i++) tick();
    if (done_log.size() < target) check("wait_done_timeout", done_log.size(), target);
  endtask

  function automatic logic [63:0] capture(input int start, input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++)
      if (start + k >= 0 && start + k < HIST) v[k] = tx_hist[start + k];
    return v;
  endfunction

  function automatic logic [63:0] expand(input logic [15:0] pat, input int nbits);
    logic [63:0] v = '0;
    for (int k = 0; k < nbits * BAUD; k++) v[k] = pat[k / BAUD];
    return v;
  endfunction

  initial begin
    int bp, bd, p, p2, c;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    refresh();
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx", tx_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_count", cnt_a, 16'h0000);
    repeat (3) tick();
    rst_n = 1'b1;

    // Empty FIFO with enable held: no pops, line idle.
    enable = 1'b1;
    repeat (100) tick();
    check("empty_pops", pop_log.size(), 0);
    check("empty_tx", tx_a, 1'b1);

    // Single 0xA5 frame, 8N1.
    bp = pop_log.size(); bd = done_log.size();
    push(8'hA5);
    wait_pops(bp + 1, 10);
    wait_dones(bd + 1, 60);
    repeat (3) tick();
    check("a5_pops", pop_log.size() - bp, 1);
    if (pop_log.size() > bp && done_log.size() > bd) begin
      p = pop_log[bp];
      check("a5_wave", capture(p + 1, 40), expand(16'b1101001010, 10));
      check("a5_done_at", done_log[bd] - p, 41);
    end
    check("a5_count", cnt_a, 16'd1);

    // Back-to-back 0x01, 0xFF after a reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bp = pop_log.size(); bd = done_log.size();
    push(8'h01);
    push(8'hFF);
    wait_pops(bp + 2, 100);
    wait_dones(bd + 2, 120);
    repeat (3) tick();
    if (pop_log.size() > bp + 1) begin
      p  = pop_log[bp];
      p2 = pop_log[bp + 1];
      check("b2b_pop_gap", p2 - p, 41);
      check("b2b_last_stop", tx_hist[p + 40], 1'b1);
      check("b2b_idle_gap", tx_hist[p + 41], 1'b1);
      check("b2b_next_start", tx_hist[p + 42], 1'b0);
      check("b2b_wave_ff", capture(p2 + 1, 40), expand(16'b1111111110, 10));
    end
    check("b2b_count", cnt_a, 16'd2);

    // 0x03 with odd parity and two stop bits.
    sel = 1'b1;
    bp = pop_log.size(); bd = done_log.size();
    push(8'h03);
    wait_pops(bp + 1, 10);
    wait_dones(bd + 1, 70);
    repeat (3) tick();
    if (pop_log.size() > bp && done_log.size() > bd) begin
      p = pop_log[bp];
      check("par_wave", capture(p + 1, 48), expand(16'b111000000110, 12));
      check("par_done_at", done_log[bd] - p, 49);
    end
    check("par_count", cnt_b, 16'd1);

    // Enable dropped mid-frame with three words queued.
    sel = 1'b0;
    bp = pop_log.size(); bd = done_log.size();
    push(8'h5A); push(8'hC3); push(8'h7E);
    wait_pops(bp + 1, 10);
    repeat (8) tick();
    enable = 1'b0;
    wait_dones(bd + 1, 60);
    repeat (20) tick();
    check("en_off_pops", pop_log.size() - bp, 1);
    check("en_off_left", fifo_q.size(), 2);
    enable = 1'b1;
    c = cyc;
    tick();
    check("en_on_pop_at", (pop_log.size() > 0) ? pop_log[$] : 0, c + 1);
    wait_dones(bd + 3, 150);

    // Random traffic on the 8N1 instance.
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(7) == 0 && fifo_q.size() < 4) push(DW'($urandom));
      if ($urandom_range(19) == 0) enable = ~enable;
    end
    enable = 1'b1;
    for (int i = 0; i < 600 && (fifo_q.size() != 0 || busy_a); i++) tick();
    repeat (3) tick();

    // Counter wrap: preload 0xFFFF while idle, then send one frame.
    force u_dut_a.frames_sent = 16'hFFFF;
    exp_cnt[0] = 16'hFFFF;
    tick();
    release u_dut_a.frames_sent;
    tick();
    bd = done_log.size();
    push(8'h96);
    wait_dones(bd + 1, 60);
    tick();
    check("wrap_count", cnt_a, 16'h0000);

    // Random traffic on the parity/2-stop instance.
    sel = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if ($urandom_range(7) == 0 && fifo_q.size() < 4) push(DW'($urandom));
      if ($urandom_range(19) == 0) enable = ~enable;
    end
    enable = 1'b1;
    for (int i = 0; i < 600 && (fifo_q.size() != 0 || busy_b); i++) tick();
    repeat (3) tick();

    // Reset in the middle of a frame: line high at once, no frame_done afterwards.
    sel = 1'b0;
    bp = pop_log.size();
    push(8'h00);
    wait_pops(bp + 1, 10);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx_a, 1'b1);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_pop", pop_a, 1'b0);
    check("midrst_count", cnt_a, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    bd = done_log.size();
    repeat (60) tick();
    check("midrst_no_done", done_log.size() - bd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's show-ahead FIFO, which has no underflow protection. It pops one word at a time using the FIFO's empty/pop/data_out signals and transmits it as an asynchronous serial frame: start bit, DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between a TX FIFO and the device pin. It is the transmit end of the link that the FIFO buffers for.

Parameters:
DATA_W, 8, word width; must match the FIFO data width.
BAUD_DIV, 16, clk cycles per serial bit; legal range 2..65535.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1; 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
enable  input  1  permits starting a new frame; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO head word; valid combinationally whenever fifo_empty=0
fifo_pop  output  1  one-cycle pop strobe to the FIFO
tx  output  1  serial line, idle high; driven from a register
busy  output  1  high while a frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse after each completed frame
frames_sent  output  16  count of completed frames; wraps

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, busy=0, frame_done=0, frames_sent=0, fifo_pop=0.
  - State=IDLE; shift register, bit counter and baud counter cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_pop = enable && !fifo_empty. This is combinational from the IDLE state and the two inputs.
  - fifo_pop is never asserted when fifo_empty=1 and never asserted outside IDLE.
  - In the pop cycle: fifo_data is captured into the shift register, parity is computed, and the state moves to START.
- Bit timing:
  - Each state holds tx for exactly BAUD_DIV cycles, timed by a baud counter that runs 0..BAUD_DIV-1.
  - The state advances when the counter reaches BAUD_DIV-1.
- Frame sequence:
  - START: tx=0 for 1 bit.
  - DATA: DATA_W bits, LSB first. The shift register shifts right at each bit boundary.
  - PARITY: present only if PARITY_EN=1. Bit value = XOR of all data bits, inverted when PARITY_ODD=1.
  - STOP: tx=1 for STOP_BITS bits, then return to IDLE.
- Latency:
  - The pop occurs in cycle T. The first start-bit cycle on tx is T+1.
  - Frame length is (1 + DATA_W + PARITY_EN + STOP_BITS) * BAUD_DIV cycles.
- frame_done and frames_sent:
  - frame_done is high for exactly one cycle: the first IDLE cycle after the final stop-bit cycle.
  - frames_sent increments in that same cycle and wraps 0xFFFF -> 0x0000.
- Back-to-back frames: with enable=1 and the FIFO non-empty, the next pop occurs in that same first IDLE cycle. This gives exactly 1 clk of idle-high gap between frames.
- Enable deasserted mid-frame: the current frame completes normally; no new pop occurs until enable=1 again.
- fifo_empty asserting mid-frame: ignored, because the word is already captured.
- Reset mid-frame:
  - tx returns high immediately and the captured word is discarded (it was already popped).
  - No frame_done pulse is produced.
- fifo_data changes after the pop: ignored; only the shift register drives tx.

Test Plan:
1. Reset values: assert rst_n=0 mid-run -> tx=1, busy=0, fifo_pop=0, frames_sent=0 in the same cycle; and with fifo_empty=1, enable=1 held 100 cycles -> fifo_pop stays 0 and tx stays 1.
2. Single word, DATA_W=8, BAUD_DIV=4, no parity, 1 stop bit, push 0xA5:
   - one fifo_pop pulse;
   - tx = 0 (4 clk), then data bits 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk) — 40 clk total;
   - frame_done pulses at clk 41; frames_sent=1.
3. Back-to-back words 0x01 and 0xFF with enable=1 -> two pops 41 clk apart; exactly 1 idle-high clk between the frames; frames_sent=2.
4. PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, send 0x03 -> parity bit=1 after the data bits; stop bits high for 2*BAUD_DIV clk; frame length is 12*BAUD_DIV.
5. Enable dropped during a DATA bit of the first of 3 queued words -> that frame finishes; no further pops; re-asserting enable -> the next pop occurs in the following IDLE cycle.
6. Preload frames_sent to 0xFFFF via 65535 frames with BAUD_DIV=2 (or force) -> the next frame_done sets frames_sent=0x0000.
